// File: rtl/mem_responder_if.sv
// Bus bundle between the memory controller (master) and mem_responder (slave).
// Carries the request strobes, address and write data, and the busy/ack/err/read-data returns.
interface mem_responder_if;
   logic [31:0] address_in;
   logic [31:0] data_in;
   logic        read_req;
   logic        write_req;
   logic        bus_full;
   logic [31:0] data_out;
   logic        ack;
   logic        err;

   modport master (
      output address_in, data_in, read_req, write_req,
      input  bus_full, data_out, ack, err
   );

   modport slave (
      input  address_in, data_in, read_req, write_req,
      output bus_full, data_out, ack, err
   );
endinterface

// File: rtl/mem_responder.sv
// Bus-side memory target with programmable wait states and a one-cycle ack.
// Optional macro MEMRESP_ERR_EN enables out-of-range address detection with err on ack.
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input logic           clk,
   input logic           rst,
   mem_responder_if.slave bus
);

   localparam int        DEPTH   = 1 << ADDR_W;
   localparam int        LAST_I  = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0] LAST   = 4'(LAST_I);
   localparam bit        NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   idx_q;
   logic [31:0]         data_q;
   logic                rd_q;
   logic                oor_q;
   logic                bus_full_r;
   logic                ack_r;
   logic                err_r;
   logic [31:0]         data_out_r;
   logic [31:0]         mem [DEPTH];

   logic                req_any;
   logic [ADDR_W-1:0]   req_idx;
   logic                req_oor;
   logic                enter_resp;
   logic                cur_rd;
   logic                cur_oor;
   logic [ADDR_W-1:0]   cur_idx;
   logic [31:0]         cur_data;
   logic                unused_addr;

   assign req_any = bus.read_req | bus.write_req;
   assign req_idx = bus.address_in[ADDR_W+1:2];

`ifdef MEMRESP_ERR_EN
   assign req_oor = |bus.address_in[31:ADDR_W+2];
`else
   assign req_oor = 1'b0;
`endif

   // Byte-offset bits never matter; upper bits only matter when range checking is built in.
   assign unused_addr = ^{bus.address_in[1:0], bus.address_in[31:ADDR_W+2]};

   // With no wait states the response edge is the accept edge, so use the live request fields.
   assign enter_resp = NO_WAIT ? (state == IDLE && req_any)
                               : (state == BUSY && cnt == LAST);
   assign cur_rd   = NO_WAIT ? bus.read_req : rd_q;
   assign cur_oor  = NO_WAIT ? req_oor      : oor_q;
   assign cur_idx  = NO_WAIT ? req_idx      : idx_q;
   assign cur_data = NO_WAIT ? bus.data_in  : data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         idx_q      <= '0;
         data_q     <= 32'h0;
         rd_q       <= 1'b0;
         oor_q      <= 1'b0;
         bus_full_r <= 1'b0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
         data_out_r <= 32'h0;
      end else begin
         ack_r <= 1'b0;
         err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  idx_q      <= req_idx;
                  data_q     <= bus.data_in;
                  rd_q       <= bus.read_req;
                  oor_q      <= req_oor;
                  cnt        <= 4'd0;
                  bus_full_r <= 1'b1;
                  state      <= NO_WAIT ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST) state <= RESP;
            end
            RESP: begin
               bus_full_r <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Commit point: the edge that enters RESP.
         if (enter_resp) begin
            ack_r <= 1'b1;
            err_r <= cur_oor;
            if (cur_rd) data_out_r <= cur_oor ? 32'h0 : mem[cur_idx];
            else if (!cur_oor) mem[cur_idx] <= cur_data;
         end
      end
   end

   assign bus.bus_full = bus_full_r;
   assign bus.ack      = ack_r;
   assign bus.err      = err_r;
   assign bus.data_out = data_out_r;

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus-side target that answers the memory controller's read/write requests. Sits on the far side of the bus from the controller: it samples address, write data and request strobes, raises `bus_full` while it is servicing a request, and holds it through a programmable wait-state period. It then commits the write, or returns read data from an internal word-addressed RAM, with a one-cycle `ack`. It also serves as the bus model that controller benches are run against.

## Interface
- `ADDR_W`, default 8: word-address width; RAM depth = 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between accept and response; legal range 0..15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `address_in`  in  32  byte address from the controller (the controller's `address_out`).
- `data_in`  in  32  write data from the controller (the controller's `data_out_BUS`).
- `read_req`  in  1  read request, level.
- `write_req`  in  1  write request, level.
- `bus_full`  out  1  busy; the controller must not expect a new accept while it is high.
- `data_out`  out  32  read data (the controller's `data_in_BUS`), registered.
- `ack`  out  1  one-cycle response strobe.
- `err`  out  1  address-range error, valid with `ack` (see Configuration).

## Operation
- Reset values: state IDLE, wait counter 0, `bus_full`=0, `ack`=0, `err`=0, `data_out`=32'h0. RAM contents are not reset.
- Word index = `address_in[ADDR_W+1:2]`. Bits [1:0] are ignored; there are no byte lanes, and every access is a full word.
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - Samples `read_req`/`write_req` every edge.
  - If either is high: latch address, write data and op, then go to BUSY, or straight to RESP when WAIT_CYCLES=0.
  - Read has precedence: if both are high, the op is a read and the write is dropped.
  - With no request, stay in IDLE.
- BUSY:
  - Counter increments each cycle.
  - Leave BUSY on the edge where counter = WAIT_CYCLES-1, then go to RESP.
  - Requests are ignored in this state.
- Edge entering RESP:
  - Read: `data_out` <= RAM[idx].
  - Write: RAM[idx] <= latched data; `data_out` is unchanged.
- RESP: `ack`=1 for exactly one cycle, then return to IDLE. Requests are ignored in this state.
- `bus_full`=1 in BUSY and RESP and 0 in IDLE. Outputs are decoded from registered state, so there are no combinational input-to-output paths.
- `data_out` holds the last read value until the next read response.
- Because the address and data are latched, input changes after the accept cycle have no effect on the transaction in flight.
- A request held high across RESP is re-accepted on the first IDLE cycle. There is no back-to-back accept from RESP.
- Reset asserted mid-transaction: return immediately to IDLE with reset output values.
  - A write not yet committed (edge entering RESP not reached) is lost.
  - A committed write persists.

## Timing
- Request sampled high at edge E0 (end of cycle 0).
- `bus_full` is high from cycle 1.
- `ack` is high in cycle 1+WAIT_CYCLES.
- `bus_full` is low again in cycle 2+WAIT_CYCLES.
- Minimum request-to-request period = WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=0: cycle 1 is RESP (`ack`=1, `bus_full`=1) and cycle 2 is IDLE.
- Read data is valid in the `ack` cycle and stays valid afterwards until the next read `ack`.

## Configuration
- Macro: `MEMRESP_ERR_EN`.
- Defined:
  - An address with any of `address_in[31:ADDR_W+2]` nonzero is out of range.
  - The transaction still runs its full wait period.
  - In RESP, `err`=1 together with `ack`=1.
  - An out-of-range write is suppressed; an out-of-range read sets `data_out` to 32'h0.
  - `err` is 0 in all other cycles.
- Undefined: the upper address bits are ignored, so the address wraps modulo 2^ADDR_W words, and `err` is tied to 0.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `read_req`=1 -> `bus_full`=0, `ack`=0, `err`=0, `data_out`=0; release `rst` -> `bus_full`=1 one cycle after the first sampled edge.
- Write then read, WAIT_CYCLES=2:
  - Write addr 32'h10, data 32'hDEADBEEF -> `ack` in cycle 3, `bus_full` high in cycles 1-3.
  - Then read 32'h10 -> `data_out`=32'hDEADBEEF in its `ack` cycle.
- Read/write precedence: `read_req`=`write_req`=1, addr 32'h10, `data_in`=32'h1234 -> read returns 32'hDEADBEEF; a following read still returns 32'hDEADBEEF.
- Busy ignore: a new write to 32'h14 is pulsed only during BUSY -> it is never accepted; a read of 32'h14 returns its prior value.
- Mid-operation reset: assert `rst`=0 in the first BUSY cycle of a write of 32'hCAFE to 32'h20 -> `bus_full` drops immediately; a later read of 32'h20 does not return 32'hCAFE (preload a known value first).
- Wrap/error, ADDR_W=8:
  - Write 32'hA5 to addr 32'h400, then read addr 32'h0.
  - With `MEMRESP_ERR_EN`: `err`=1 on the write `ack`, and the read of 32'h0 returns its preloaded value.
  - Without: `err`=0, and the read of 32'h0 returns 32'hA5.
